v4_peak_picker: RTL

Consumer of the trapezoidal shaping filter output stream. Detects pulses on the filtered data by threshold crossing, samples the flat-top amplitude a fixed delay after the crossing, timestamps each event and delivers it over a valid/ready handshake to the readout logic. Sits directly after the shaping filter in the ADC channel chain, one instance per channel.

---
 rtl/v4_peak_picker_pkg.sv | 23 ++
 rtl/v4_sat_counter.sv | 23 ++
 rtl/v4_peak_picker.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/v4_peak_picker_pkg.sv
// Shared constants and types for the v4 peak picker (filter timing, default widths, FSM state).
// The optional pile-up rejection is enabled by defining PILEUP_REJECT_EN.
package v4_peak_picker_pkg;

    // Shaping filter data width and trapezoid timing
    localparam int SIZE_FILTER_DATA = 16;
    localparam int FILTER_RISE_LEN  = 8;
    localparam int FILTER_FLAT_LEN  = 48;

    // The flat top starts one rise time after the crossing
    localparam int DEF_PEAK_DELAY = FILTER_RISE_LEN;
    localparam int DEF_MAX_WIDTH  = 2 * FILTER_RISE_LEN + FILTER_FLAT_LEN;

    localparam int DEF_TS_W  = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RISE,
        ST_TAIL
    } pp_state_e;

endpackage

// File: rtl/v4_sat_counter.sv
// Enable-increment counter that sticks at all-ones instead of wrapping.
module v4_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/v4_peak_picker.sv
// Threshold-crossing peak picker: timestamps each pulse, samples its flat-top amplitude
// and hands events out over valid/ready. Define PILEUP_REJECT_EN to hold events until pulse end.
module v4_peak_picker
    import v4_peak_picker_pkg::*;
#(
    parameter int DATA_W     = SIZE_FILTER_DATA,
    parameter int PEAK_DELAY = DEF_PEAK_DELAY,
    parameter int MAX_WIDTH  = DEF_MAX_WIDTH,
    parameter int TS_W       = DEF_TS_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] thr,
    output logic [DATA_W-1:0] amp_data,
    output logic [TS_W-1:0]   amp_ts,
    output logic              amp_valid,
    input  logic              amp_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  pileup_cnt
);

    if (PEAK_DELAY < 1 || PEAK_DELAY > 255) begin : g_bad_peak_delay
        $error("v4_peak_picker: PEAK_DELAY must be in 1..255");
    end
    if (MAX_WIDTH < 1) begin : g_bad_max_width
        $error("v4_peak_picker: MAX_WIDTH must be at least 1");
    end

    // The delay counter is 0 on the crossing edge, so it reads PEAK_DELAY-1 on the sample edge
    localparam logic [7:0] DLY_LAST = 8'(PEAK_DELAY - 1);

    pp_state_e         state_q;
    logic              armed_q;
    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   cross_ts_q;
    logic [7:0]        dly_q;
    logic              below;
    logic              sample_now;

    logic              emit;
    logic [DATA_W-1:0] emit_data;
    logic              drop_inc;
    logic              pileup_inc;

    logic [DATA_W-1:0] amp_data_q;
    logic [TS_W-1:0]   amp_ts_q;
    logic              amp_valid_q;

    assign below      = (data_in < thr);
    assign sample_now = (state_q == ST_RISE) && !below && (dly_q == DLY_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // NOTE: all state updates use <= so every branch sees the pre-edge values of state_q/armed_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            cross_ts_q <= '0;
            dly_q      <= '0;
        end else begin
            if (below) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (!below && armed_q) begin
                        state_q    <= ST_RISE;
                        armed_q    <= 1'b0;
                        cross_ts_q <= ts_q;
                        dly_q      <= '0;
                    end
                end
                ST_RISE: begin
                    // Falling back before the sample point is treated as noise
                    if (below) begin
                        state_q <= ST_IDLE;
                    end else if (dly_q == DLY_LAST) begin
                        state_q <= ST_TAIL;
                    end else begin
                        dly_q <= dly_q + 8'd1;
                    end
                end
                ST_TAIL: begin
                    if (below) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef PILEUP_REJECT_EN
    localparam int               WID_W   = $clog2(MAX_WIDTH + 2);
    localparam logic [WID_W-1:0] WID_SAT = WID_W'(MAX_WIDTH + 1);
    localparam logic [WID_W-1:0] WID_MAX = WID_W'(MAX_WIDTH);

    // wid_q holds (cycles above threshold - 1) once the pulse has ended
    logic [WID_W-1:0]  wid_q;
    logic [DATA_W-1:0] amp_hold_q;
    logic              pulse_end;

    assign pulse_end = (state_q == ST_TAIL) && below;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wid_q      <= '0;
            amp_hold_q <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                wid_q <= '0;
            end else if (!below && (wid_q != WID_SAT)) begin
                wid_q <= wid_q + WID_W'(1);
            end
            if (sample_now) begin
                amp_hold_q <= data_in;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        emit       = 1'b0;
        pileup_inc = 1'b0;
        emit_data  = amp_hold_q;
        if (pulse_end) begin
            if (wid_q >= WID_MAX) begin
                pileup_inc = 1'b1;
            end else begin
                emit = 1'b1;
            end
        end
    end
`else
    always_comb begin
        emit       = sample_now;
        pileup_inc = 1'b0;
        emit_data  = data_in;
    end
`endif

    assign drop_inc = emit && amp_valid_q && !amp_ready;

    // Accepting the held event and loading a new one can happen on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            amp_data_q  <= '0;
            amp_ts_q    <= '0;
            amp_valid_q <= 1'b0;
        end else if (emit && (!amp_valid_q || amp_ready)) begin
            amp_data_q  <= emit_data;
            amp_ts_q    <= cross_ts_q;
            amp_valid_q <= 1'b1;
        end else if (amp_ready) begin
            amp_valid_q <= 1'b0;
        end
    end

    assign amp_data  = amp_data_q;
    assign amp_ts    = amp_ts_q;
    assign amp_valid = amp_valid_q;

    v4_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt)
    );

    v4_sat_counter #(.W(CNT_W)) u_pileup_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (pileup_inc),
        .cnt_o (pileup_cnt)
    );

endmodule
